wb_port_sched: RTL and testbench

Write-back port scheduler for the MIPS-C core register file. It shares the register file's single write port between three write-back sources: load/store unit, multiply/divide unit and ALU. It also keeps a 31-entry pending-write scoreboard that flags read-after-write hazards to decode. It sits between the execution units and the register file's RD/WData/RegWrite inputs.

---
 rtl/wb_port_sched.sv | 153 +++++++++++++++
 tb/tb_wb_port_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_sched.sv
// Write-back port scheduler: arbitrates LSU/MDU/ALU onto the single register
// file write port and tracks pending writes. Round-robin when WB_SCHED_RR_EN.
module wb_port_sched #(
    parameter int NREQ = 3
) (
    input  logic            CLK_I,
    input  logic            Reset_N_I,
    input  logic [NREQ-1:0] Req_I,
    input  logic [4:0]      RD0_I,
    input  logic [4:0]      RD1_I,
    input  logic [4:0]      RD2_I,
    input  logic [31:0]     WData0_I,
    input  logic [31:0]     WData1_I,
    input  logic [31:0]     WData2_I,
    output logic [NREQ-1:0] Ack_O,
    output logic            RegWrite_O,
    output logic [4:0]      RD_O,
    output logic [31:0]     WData_O,
    input  logic            Issue_I,
    input  logic [4:0]      IssueRD_I,
    input  logic [4:0]      RS1_I,
    input  logic [4:0]      RS2_I,
    output logic            Hazard_O,
    output logic [31:0]     Busy_O,
    output logic            Err_O
);

    logic [2:0]  grant;
    logic [4:0]  sel_rd;
    logic [31:0] sel_wd;

    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q, busy_d;
    logic        err_q, err_d;

`ifdef WB_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;

    // Round-robin search starting at the requester named by the pointer
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = 0; i < 3; i++) begin
            idx = 2'((int'(ptr_q) + i) % 3);
            if (grant == 3'b000 && Req_I[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted
    always_comb begin
        ptr_d = ptr_q;
        unique case (1'b1)
            grant[0]: ptr_d = 2'd1;
            grant[1]: ptr_d = 2'd2;
            grant[2]: ptr_d = 2'd0;
            default:  ptr_d = ptr_q;
        endcase
    end

    // Round-robin pointer register
    always_ff @(posedge CLK_I or negedge Reset_N_I) begin
        if (!Reset_N_I) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: LSU over MDU over ALU
    always_comb begin
        grant    = '0;
        grant[0] = Req_I[0];
        grant[1] = Req_I[1] & ~Req_I[0];
        grant[2] = Req_I[2] & ~Req_I[1] & ~Req_I[0];
    end
`endif

    assign Ack_O = Reset_N_I ? grant : '0;

    // Steer the winning requester's index and data to the port
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        unique case (1'b1)
            grant[0]: begin sel_rd = RD0_I; sel_wd = WData0_I; end
            grant[1]: begin sel_rd = RD1_I; sel_wd = WData1_I; end
            grant[2]: begin sel_rd = RD2_I; sel_wd = WData2_I; end
            default:  begin sel_rd = '0;    sel_wd = '0;       end
        endcase
    end

    // Next write-port state; writes to r0 are acked but not enabled
    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (grant != 3'b000) begin
            regwrite_d = (sel_rd != 5'd0);
            rd_d       = sel_rd;
            wdata_d    = sel_wd;
        end
    end

    // Scoreboard update: retire first, then a new issue overrides it
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (regwrite_q) begin
            busy_d[rd_q] = 1'b0;
            if (!busy_q[rd_q]) begin
                err_d = 1'b1;
            end
        end
        if (Issue_I && IssueRD_I != 5'd0) begin
            busy_d[IssueRD_I] = 1'b1;
            if (busy_q[IssueRD_I]) begin
                err_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Write-port and scoreboard registers
    always_ff @(posedge CLK_I or negedge Reset_N_I) begin
        if (!Reset_N_I) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign RegWrite_O = regwrite_q;
    assign RD_O       = rd_q;
    assign WData_O    = wdata_q;
    assign Busy_O     = busy_q;
    assign Err_O      = err_q;
    assign Hazard_O   = (RS1_I != 5'd0 && busy_q[RS1_I]) ||
                        (RS2_I != 5'd0 && busy_q[RS2_I]);

endmodule

// File: tb/tb_wb_port_sched.sv
// Bench for wb_port_sched: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model of the scheduler.
module tb_wb_port_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [4:0]  rd_a [3];
    logic [31:0] wd_a [3];
    logic [2:0]  Ack_O;
    logic        RegWrite_O;
    logic [4:0]  RD_O;
    logic [31:0] WData_O;
    logic        issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        Hazard_O;
    logic [31:0] Busy_O;
    logic        Err_O;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_sched #(.NREQ(3)) dut (
        .CLK_I(clk), .Reset_N_I(rst_n), .Req_I(req),
        .RD0_I(rd_a[0]), .RD1_I(rd_a[1]), .RD2_I(rd_a[2]),
        .WData0_I(wd_a[0]), .WData1_I(wd_a[1]), .WData2_I(wd_a[2]),
        .Ack_O(Ack_O), .RegWrite_O(RegWrite_O), .RD_O(RD_O),
        .WData_O(WData_O), .Issue_I(issue), .IssueRD_I(issue_rd),
        .RS1_I(rs1), .RS2_I(rs2), .Hazard_O(Hazard_O),
        .Busy_O(Busy_O), .Err_O(Err_O)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_busy;
    bit        m_err, m_rw;
    bit [4:0]  m_rd;
    bit [31:0] m_wd;
    int        m_ptr;
    bit [31:0] n_busy;
    bit        n_err, n_rw;
    bit [4:0]  n_rd;
    bit [31:0] n_wd;
    int        n_ptr;
    bit        nx_valid = 1'b0;

    // Winner: first requesting index in the configured priority order
    function automatic int exp_grant(input bit [2:0] r, input int p);
`ifdef WB_SCHED_RR_EN
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
`else
        for (int k = 0; k < 3; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    always @(negedge rst_n) begin
        m_busy = '0; m_err = 0; m_rw = 0; m_rd = '0; m_wd = '0;
        m_ptr = 0; nx_valid = 0;
    end

    always @(negedge clk) begin
        int g;
        bit [2:0] ea;
        bit hz;
        if (!rst_n) begin
            nx_valid = 0;
            chk("rst_ack", 32'(Ack_O), 0);
            chk("rst_regwrite", 32'(RegWrite_O), 0);
            chk("rst_busy", Busy_O, 0);
            chk("rst_err", 32'(Err_O), 0);
        end else begin
            g  = exp_grant(req, m_ptr);
            ea = (g < 0) ? 3'b000 : 3'(1 << g);
            hz = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
            chk("m_ack", 32'(Ack_O), 32'(ea));
            chk("m_regwrite", 32'(RegWrite_O), 32'(m_rw));
            chk("m_rd", 32'(RD_O), 32'(m_rd));
            chk("m_wdata", WData_O, m_wd);
            chk("m_busy", Busy_O, m_busy);
            chk("m_err", 32'(Err_O), 32'(m_err));
            chk("m_hazard", 32'(Hazard_O), 32'(hz));
            n_rd = m_rd; n_wd = m_wd; n_rw = 0; n_ptr = m_ptr;
            if (g >= 0) begin
                n_rd  = rd_a[g];
                n_wd  = wd_a[g];
                n_rw  = (rd_a[g] != 0);
                n_ptr = (g + 1) % 3;
            end
            n_busy = m_busy;
            n_err  = m_err;
            if (m_rw) begin
                n_busy[m_rd] = 0;
                if (!m_busy[m_rd]) n_err = 1;
            end
            if (issue && issue_rd != 0) begin
                n_busy[issue_rd] = 1;
                if (m_busy[issue_rd]) n_err = 1;
            end
            nx_valid = 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && nx_valid) begin
            m_busy = n_busy; m_err = n_err; m_rw = n_rw;
            m_rd = n_rd; m_wd = n_wd; m_ptr = n_ptr;
            nx_valid = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic clr_inputs;
        req = '0; issue = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 3; i++) begin
            rd_a[i] = '0;
            wd_a[i] = '0;
        end
    endtask

    task automatic do_reset;
        rst_n = 0;
        clr_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        bit [2:0] a;
        bit [2:0] exp_c [3];
        clr_inputs();
        tick();
        do_reset();

        // reset state
        at_neg();
        chk("reset_regwrite", 32'(RegWrite_O), 0);
        chk("reset_rd", 32'(RD_O), 0);
        chk("reset_busy", Busy_O, 0);
        chk("reset_hazard", 32'(Hazard_O), 0);
        tick();

        // single ALU write
        req = 3'b100; rd_a[2] = 5'd5; wd_a[2] = 32'hDEADBEEF;
        at_neg();
        chk("single_ack", 32'(Ack_O), 32'h4);
        tick();
        req = '0;
        at_neg();
        chk("single_regwrite", 32'(RegWrite_O), 1);
        chk("single_rd", 32'(RD_O), 5);
        chk("single_wdata", WData_O, 32'hDEADBEEF);
        tick();

        // contention
        do_reset();
        req = 3'b111;
        rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd3;
`ifdef WB_SCHED_RR_EN
        exp_c[0] = 3'b001; exp_c[1] = 3'b010; exp_c[2] = 3'b100;
`else
        exp_c[0] = 3'b001; exp_c[1] = 3'b001; exp_c[2] = 3'b001;
`endif
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk($sformatf("contend_ack%0d", i), 32'(Ack_O), 32'(exp_c[i]));
            tick();
        end

        // r0 drop
        do_reset();
        req = 3'b001; rd_a[0] = 5'd0; wd_a[0] = 32'h1234;
        at_neg();
        chk("r0_ack", 32'(Ack_O), 1);
        tick();
        req = '0;
        at_neg();
        chk("r0_regwrite", 32'(RegWrite_O), 0);
        chk("r0_busy", Busy_O, 0);
        tick();

        // scoreboard hazard lifetime
        do_reset();
        issue = 1; issue_rd = 5'd7;
        tick();
        issue = 0; rs1 = 5'd7;
        at_neg();
        chk("sb_hazard_set", 32'(Hazard_O), 1);
        tick();
        req = 3'b100; rd_a[2] = 5'd7; wd_a[2] = 32'h5A5A5A5A;
        at_neg();
        chk("sb_ack", 32'(Ack_O), 32'h4);
        chk("sb_hazard_t", 32'(Hazard_O), 1);
        tick();
        req = '0;
        at_neg();
        chk("sb_hazard_t1", 32'(Hazard_O), 1);
        chk("sb_regwrite", 32'(RegWrite_O), 1);
        tick();
        at_neg();
        chk("sb_hazard_t2", 32'(Hazard_O), 0);
        chk("sb_err", 32'(Err_O), 0);
        tick();

        // WAW error and set/clear collision
        do_reset();
        issue = 1; issue_rd = 5'd9;
        tick();
        at_neg();
        chk("waw_err_before", 32'(Err_O), 0);
        tick();
        issue = 0;
        at_neg();
        chk("waw_err", 32'(Err_O), 1);
        chk("waw_busy9", 32'(Busy_O[9]), 1);
        tick();
        tick();
        tick();
        at_neg();
        chk("waw_err_sticky", 32'(Err_O), 1);
        tick();
        issue = 1; issue_rd = 5'd3;
        tick();
        issue = 0; req = 3'b100; rd_a[2] = 5'd3; wd_a[2] = 32'h33;
        tick();
        req = '0; issue = 1; issue_rd = 5'd3;
        at_neg();
        chk("coll_regwrite", 32'(RegWrite_O), 1);
        chk("coll_rd", 32'(RD_O), 3);
        tick();
        issue = 0;
        at_neg();
        chk("coll_busy3", 32'(Busy_O[3]), 1);
        tick();

        // asynchronous reset mid-cycle with all requests up
        req = 3'b111; rs1 = 5'd9;
        rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd3;
        #2;
        rst_n = 0;
        #1;
        chk("arst_ack", 32'(Ack_O), 0);
        chk("arst_regwrite", 32'(RegWrite_O), 0);
        chk("arst_rd", 32'(RD_O), 0);
        chk("arst_wdata", WData_O, 0);
        chk("arst_busy", Busy_O, 0);
        chk("arst_err", 32'(Err_O), 0);
        chk("arst_hazard", 32'(Hazard_O), 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        tick();
        tick();

        // randomized traffic; requesters hold until acked
        for (int c = 0; c < 3000; c++) begin
            at_neg();
            a = Ack_O;
            tick();
            if (c % 700 == 699) begin
                rst_n = 0;
                tick();
                tick();
                rst_n = 1;
                continue;
            end
            for (int n = 0; n < 3; n++) begin
                if (a[n] || !req[n]) begin
                    req[n] = ($urandom_range(0, 9) < 5);
                    rd_a[n] = ($urandom_range(0, 3) == 0) ?
                              5'($urandom_range(0, 31)) :
                              5'($urandom_range(0, 7));
                    wd_a[n] = $urandom;
                end
            end
            issue    = ($urandom_range(0, 9) < 3);
            issue_rd = 5'($urandom_range(0, 7));
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
        end

        clr_inputs();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
